// File: rtl/pacman_irq_ctrl.sv
// Game interrupt source: debounced keys, fixed-rate tick and vsync latched into W1C pending bits, gated by a mask into d_irq.
// irq and avs_readdata are registered (one cycle latency); the slave never stalls, so there is no backpressure.
module pacman_irq_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 60,
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                vga_vsync_n,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic [31:0]         irq
);

  localparam int NP          = NUM_KEYS + 2;
  localparam int TICK_PERIOD = CLK_HZ / TICK_HZ;
  localparam int TW          = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int DW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  // Keys are synchronized already inverted, so a cleared flop means "released".
  logic [NUM_KEYS-1:0] kp_s1, kp_s2, key_state, key_evt;
  logic [DW-1:0]       db_cnt [NUM_KEYS];
  logic                vs_s1, vs_s2, vs_s3;
  logic [TW-1:0]       tick_div;
  logic                tick_wrap;
  logic [15:0]         tick_count;
  logic [NP-1:0]       pending, mask, evt, w1c;
  logic                wr_pend, wr_mask, wr_tick;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^avs_writedata[31:NP];

  always_comb begin
    key_evt = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      key_evt[k] = kp_s2[k] & ~key_state[k] & (db_cnt[k] == DB_LAST);
    end
    tick_wrap = (tick_div == TICK_LAST);
    evt       = {vs_s3 & ~vs_s2, tick_wrap, key_evt};
    wr_pend   = avs_write && (avs_address == 2'd0);
    wr_mask   = avs_write && (avs_address == 2'd1);
    wr_tick   = avs_write && (avs_address == 2'd3);
    w1c       = wr_pend ? avs_writedata[NP-1:0] : '0;
    case (avs_address)
      2'd0:    rd_mux = {{(32-NP){1'b0}}, pending};
      2'd1:    rd_mux = {{(32-NP){1'b0}}, mask};
      2'd2:    rd_mux = {{(32-NUM_KEYS){1'b0}}, key_state};
      default: rd_mux = {16'd0, tick_count};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kp_s1     <= '0;
      kp_s2     <= '0;
      key_state <= '0;
      for (int k = 0; k < NUM_KEYS; k++) db_cnt[k] <= '0;
      vs_s1     <= 1'b0;
      vs_s2     <= 1'b0;
      vs_s3     <= 1'b0;
    end else begin
      kp_s1 <= ~key_n;
      kp_s2 <= kp_s1;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (kp_s2[k] == key_state[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          key_state[k] <= kp_s2[k];
          db_cnt[k]    <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DW'(1);
        end
      end
      vs_s1 <= vga_vsync_n;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_div   <= '0;
      tick_count <= '0;
    end else begin
      tick_div <= tick_wrap ? '0 : tick_div + TW'(1);
      // A clear that coincides with a wrap still counts that wrap.
      if (wr_tick)        tick_count <= {15'd0, tick_wrap};
      else if (tick_wrap) tick_count <= tick_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      mask         <= '0;
      avs_readdata <= '0;
      irq          <= '0;
    end else begin
      pending <= (pending & ~w1c) | evt;
      if (wr_mask)  mask <= avs_writedata[NP-1:0];
      if (avs_read) avs_readdata <= rd_mux;
      irq <= {29'd0,
              pending[NP-1] & mask[NP-1],
              pending[NP-2] & mask[NP-2],
              |(pending[NUM_KEYS-1:0] & mask[NUM_KEYS-1:0])};
    end
  end

endmodule

// File: tb/tb_pacman_irq_ctrl.sv
// Bench for pacman_irq_ctrl: directed scenarios plus random traffic, every cycle compared against an event-level model.
module tb_pacman_irq_ctrl;
  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int P = CLK_HZ / TICK_HZ;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic          vga_vsync_n;
  logic [1:0]    avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata, avs_readdata, irq;

  pacman_irq_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .vga_vsync_n(vga_vsync_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: registers as plain ints, inputs seen through a two-sample delay line,
  // a key is accepted once its last DB observed samples all disagree with its debounced state.
  int m_pend, m_mask, m_kst, m_tcnt, m_irq, m_rdata, m_cyc;
  int win [NK];
  logic [NK-1:0] kh0, kh1;
  logic vh0, vh1, vh2;

  task automatic model_step();
    logic [NK-1:0] obs;
    logic v_evt, wrap;
    int evt, new_kst, clr, full;
    full = (1 << DB) - 1;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_kst = 0; m_tcnt = 0; m_irq = 0; m_rdata = 0; m_cyc = 0;
      kh0 = '0; kh1 = '0; vh0 = 0; vh1 = 0; vh2 = 0;
      for (int k = 0; k < NK; k++) win[k] = 0;
      return;
    end
    obs = kh1; kh1 = kh0; kh0 = ~key_n;
    v_evt = vh2 && !vh1; vh2 = vh1; vh1 = vh0; vh0 = vga_vsync_n;
    m_cyc++;
    wrap = (m_cyc % P == 0);
    evt = 0;
    new_kst = m_kst;
    for (int k = 0; k < NK; k++) begin
      win[k] = ((win[k] << 1) | int'(obs[k])) & full;
      if (((m_kst >> k) & 1) == 0 && win[k] == full) begin
        new_kst |= (1 << k);
        evt |= (1 << k);
      end else if (((m_kst >> k) & 1) == 1 && win[k] == 0) begin
        new_kst &= ~(1 << k);
      end
    end
    evt |= (int'(wrap) << NK) | (int'(v_evt) << (NK + 1));
    if (avs_read) begin
      case (avs_address)
        2'd0: m_rdata = m_pend;
        2'd1: m_rdata = m_mask;
        2'd2: m_rdata = m_kst;
        default: m_rdata = m_tcnt;
      endcase
    end
    m_irq = (((m_pend & m_mask & ((1 << NK) - 1)) != 0) ? 1 : 0)
          | (((m_pend >> NK) & (m_mask >> NK) & 1) << 1)
          | (((m_pend >> (NK + 1)) & (m_mask >> (NK + 1)) & 1) << 2);
    clr = (avs_write && avs_address == 2'd0) ? (avs_writedata & 32'h3F) : 0;
    m_pend = (m_pend & ~clr) | evt;
    if (avs_write && avs_address == 2'd1) m_mask = avs_writedata & 32'h3F;
    if (avs_write && avs_address == 2'd3) m_tcnt = wrap ? 1 : 0;
    else if (wrap) m_tcnt = (m_tcnt + 1) & 16'hFFFF;
    m_kst = new_kst;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("irq", irq, m_irq);
    chk("readdata", avs_readdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    avs_address = 2'(a);
    avs_read = 1'b1;
    step();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    avs_address = 2'(a);
    avs_writedata = d;
    avs_write = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic align_to_wrap();
    for (int i = 0; i < 2 * P && ((m_cyc + 1) % P) != 0; i++) step();
  endtask

  logic [31:0] rdv;

  initial begin
    reset = 1'b1; key_n = '1; vga_vsync_n = 1'b1;
    avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    step();
    reset = 1'b0;
    chk("rst_irq", irq, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(a, rdv);
      chk("rst_reg", rdv, 32'd0);
    end

    // Free-running tick with everything enabled: wraps at cycles 10, 20, 30.
    wr(1, 32'h3F);
    idle(5);
    chk("tick_pre_irq", irq, 32'd0);
    idle(1);
    chk("tick_irq1", irq, 32'd2);
    idle(19);
    rd(3, rdv);
    chk("tick_count3", rdv, 32'd3);
    wr(0, 32'h3F);

    // Short bounce is rejected, a held press is accepted once.
    key_n[2] = 1'b0; idle(3); key_n[2] = 1'b1; idle(8);
    rd(0, rdv); chk("bounce_pend", rdv & 32'hF, 32'd0);
    rd(2, rdv); chk("bounce_kst", rdv, 32'd0);
    key_n[2] = 1'b0; idle(10);
    rd(0, rdv); chk("press_pend", rdv & 32'hF, 32'h4);
    rd(2, rdv); chk("press_kst", rdv, 32'h4);
    chk("press_irq0", irq & 32'h1, 32'h1);
    wr(0, 32'h4); idle(1);
    chk("w1c_irq0", irq & 32'h1, 32'h0);
    key_n[2] = 1'b1; idle(8);

    // Vsync latches while masked; unmasking raises irq[2] the next cycle.
    wr(1, 32'h0);
    vga_vsync_n = 1'b0; step(); vga_vsync_n = 1'b1; idle(4);
    rd(0, rdv); chk("vs_pend", (rdv >> 5) & 32'h1, 32'h1);
    chk("vs_masked", irq & 32'h4, 32'h0);
    wr(1, 32'h20); step();
    chk("vs_unmask", irq & 32'h4, 32'h4);

    // Same-cycle set vs clear, and tick clear on the wrap cycle.
    wr(0, 32'h3F);
    align_to_wrap();
    wr(0, 32'h10);
    rd(0, rdv); chk("set_wins", (rdv >> 4) & 32'h1, 32'h1);
    align_to_wrap();
    wr(3, 32'h0);
    rd(3, rdv); chk("tclr_wrap", rdv, 32'h1);

    // Reset mid-debounce: held key only reappears after a full resync + debounce.
    key_n[1] = 1'b0; idle(4);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_irq", irq, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(a, rdv);
      chk("mid_rst_reg", rdv, 32'd0);
    end
    rd(0, rdv); chk("held_early", rdv, 32'h0);
    idle(1);
    rd(0, rdv); chk("held_late", rdv, 32'h2);
    key_n[1] = 1'b1; idle(8);

    // Read data is held between reads; key-state upper bits read zero.
    wr(1, 32'h15);
    rd(1, rdv); chk("rd_mask", rdv, 32'h15);
    idle(3);
    chk("rd_hold", avs_readdata, 32'h15);
    key_n[3] = 1'b0; idle(8);
    rd(2, rdv); chk("rd_kst", rdv, 32'h8);
    chk("rd_kst_hi", rdv >> 4, 32'h0);
    key_n[3] = 1'b1; idle(8);

    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 9) == 0) key_n[k] = ~key_n[k];
      if ($urandom_range(0, 7) == 0) vga_vsync_n = ~vga_vsync_n;
      reset = ($urandom_range(0, 399) == 0);
      avs_address = 2'($urandom_range(0, 3));
      avs_writedata = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: begin avs_read = 1'b1; avs_write = 1'b0; end
        3, 4:    begin avs_read = 1'b0; avs_write = 1'b1; end
        5:       begin avs_read = 1'b1; avs_write = 1'b1; end
        default: begin avs_read = 1'b0; avs_write = 1'b0; end
      endcase
      step();
    end
    reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
